// File: rtl/riscv_bp_table_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bp_table_ctrl
//  Description : Branch-prediction counter table controller. Serves one
//                lookup per cycle from fetch, accepts resolved-branch
//                write-backs, and sweeps the table with INIT_VALUE after
//                reset or a clear request.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_bp_table_ctrl #(
  parameter int         XLEN           = 32,
  parameter int         BP_GLOBAL_BITS = 2,
  parameter int         BP_LOCAL_BITS  = 10,
  parameter int         HAS_RVC        = 0,
  parameter logic [1:0] INIT_VALUE     = 2'b01
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      bp_clear,
  output logic                      bp_init_busy,
  input  logic                      if_stall,
  input  logic [XLEN-1:0]           if_pc,
  input  logic [BP_GLOBAL_BITS-1:0] if_bp_history,
  output logic [1:0]                if_bp_predict,
  input  logic [XLEN-1:0]           bu_pc,
  input  logic                      bu_bp_update,
  input  logic                      bu_bp_btaken,
  input  logic [1:0]                bu_bp_predict,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history
);

  localparam int c_LSB   = (HAS_RVC != 0) ? 1 : 2;
  localparam int c_IDX_W = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int c_DEPTH = 1 << c_IDX_W;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = '1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_IDX_W-1:0] r_init_idx;
  logic [c_IDX_W-1:0] w_init_idx_nxt;

  logic [1:0]         r_table [0:c_DEPTH-1];
  logic [1:0]         r_predict;

  logic [c_IDX_W-1:0] w_lk_idx;
  logic [c_IDX_W-1:0] w_upd_idx;
  logic [1:0]         w_upd_val;
  logic               w_we;
  logic [c_IDX_W-1:0] w_widx;
  logic [1:0]         w_wdata;
  logic               w_bypass;
  logic               w_unused;

  assign w_lk_idx  = {if_bp_history, if_pc[c_LSB+BP_LOCAL_BITS-1:c_LSB]};
  assign w_upd_idx = {bu_bp_history, bu_pc[c_LSB+BP_LOCAL_BITS-1:c_LSB]};

  // PC bits outside the index window are intentionally ignored.
  assign w_unused = ^{if_pc, bu_pc};

  // Saturating counter step computed from the counter seen at predict time.
  always_comb begin
    w_upd_val = bu_bp_predict;
    if (bu_bp_btaken) begin
      if (bu_bp_predict != 2'b11) w_upd_val = bu_bp_predict + 2'd1;
    end else begin
      if (bu_bp_predict != 2'b00) w_upd_val = bu_bp_predict - 2'd1;
    end
  end

  // State register and sweep index; reset restarts the sweep at entry 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  // Next-state: walk every entry once, then run; a clear always wins.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    case (r_state)
      ST_INIT: begin
        if (r_init_idx == c_LAST_IDX) begin
          w_state_nxt    = ST_RUN;
          w_init_idx_nxt = '0;
        end else begin
          w_init_idx_nxt = r_init_idx + 1'b1;
        end
      end
      ST_RUN:  ;
      default: w_state_nxt = ST_INIT;
    endcase
    if (bp_clear) begin
      w_state_nxt    = ST_INIT;
      w_init_idx_nxt = '0;
    end
  end

  assign bp_init_busy = (r_state == ST_INIT);

  // Single write port: the sweep owns it in INIT, updates only in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = r_init_idx;
    w_wdata = INIT_VALUE;
    if (r_state == ST_INIT) begin
      w_we = 1'b1;
    end else if (bu_bp_update && !bp_clear) begin
      w_we    = 1'b1;
      w_widx  = w_upd_idx;
      w_wdata = w_upd_val;
    end
  end

  // Table storage is not reset; only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (w_we) r_table[w_widx] <= w_wdata;
  end

  // Forward a same-cycle update so the lookup never sees a stale counter.
  assign w_bypass = w_we && (r_state == ST_RUN) && (w_widx == w_lk_idx);

  // Registered lookup result: forced to 0 during the sweep, held on stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_predict <= 2'b00;
    end else if (r_state == ST_INIT) begin
      r_predict <= 2'b00;
    end else if (!if_stall) begin
      r_predict <= w_bypass ? w_wdata : r_table[w_lk_idx];
    end
  end

  assign if_bp_predict = r_predict;

endmodule
`default_nettype wire

// File: tb/tb_riscv_bp_table_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_bp_table_ctrl
//  Description : Randomised self-checking bench for riscv_bp_table_ctrl with
//                a table-array reference model; a second instance covers
//                the compressed-ISA index and reset during the sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_bp_table_ctrl;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: default parameters.
  logic        rstn = 1'b0, bp_clear = 1'b0, if_stall = 1'b0;
  logic [31:0] if_pc = '0, bu_pc = '0;
  logic [1:0]  if_hist = '0, bu_hist = '0, bu_pred = '0;
  logic        bu_upd = 1'b0, bu_tk = 1'b0;
  logic        busy;
  logic [1:0]  pred;

  riscv_bp_table_ctrl dut0 (
    .clk(clk), .rstn(rstn), .bp_clear(bp_clear), .bp_init_busy(busy),
    .if_stall(if_stall), .if_pc(if_pc), .if_bp_history(if_hist),
    .if_bp_predict(pred), .bu_pc(bu_pc), .bu_bp_update(bu_upd),
    .bu_bp_btaken(bu_tk), .bu_bp_predict(bu_pred), .bu_bp_history(bu_hist)
  );

  // Instance 1: compressed instructions enabled.
  logic        rstn1 = 1'b0, bp_clear1 = 1'b0, if_stall1 = 1'b0;
  logic [31:0] if_pc1 = '0, bu_pc1 = '0;
  logic [1:0]  if_hist1 = '0, bu_hist1 = '0, bu_pred1 = '0;
  logic        bu_upd1 = 1'b0, bu_tk1 = 1'b0;
  logic        busy1;
  logic [1:0]  pred1;

  riscv_bp_table_ctrl #(.HAS_RVC(1)) dut1 (
    .clk(clk), .rstn(rstn1), .bp_clear(bp_clear1), .bp_init_busy(busy1),
    .if_stall(if_stall1), .if_pc(if_pc1), .if_bp_history(if_hist1),
    .if_bp_predict(pred1), .bu_pc(bu_pc1), .bu_bp_update(bu_upd1),
    .bu_bp_btaken(bu_tk1), .bu_bp_predict(bu_pred1), .bu_bp_history(bu_hist1)
  );

  // Reference model: one 2-bit counter per entry plus the expected output.
  logic [1:0] model [DEPTH];
  logic [1:0] exp_pred = 2'b00;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int idx0(input logic [31:0] pc, input logic [1:0] h);
    return int'(h) * 1024 + int'((pc / 4) % 1024);
  endfunction

  function automatic logic [1:0] sat_next(input logic [1:0] p, input logic tk);
    int v;
    v = int'(p) + (tk ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic fill_model(input logic [1:0] v);
    for (int i = 0; i < DEPTH; i++) model[i] = v;
  endtask

  // One RUN-state cycle on instance 0, predicted by the model, then checked.
  task automatic step0(input logic stall, input logic [31:0] pc, input logic [1:0] h,
                       input logic upd, input logic [31:0] bpc, input logic [1:0] bh,
                       input logic tk, input logic [1:0] bp, input string tag);
    int li, wi;
    logic [1:0] nv;
    if_stall = stall; if_pc = pc; if_hist = h;
    bu_upd = upd; bu_pc = bpc; bu_hist = bh; bu_tk = tk; bu_pred = bp;
    li = idx0(pc, h);
    wi = idx0(bpc, bh);
    nv = sat_next(bp, tk);
    if (!stall) exp_pred = (upd && wi == li) ? nv : model[li];
    if (upd) model[wi] = nv;
    @(posedge clk); #1;
    bu_upd = 1'b0;
    check_val(tag, pred, exp_pred);
  endtask

  task automatic wait_init(input bit which, output int n);
    n = 0;
    while (((which == 1'b0) ? busy : busy1) && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic step1(input logic [31:0] pc, input logic upd, input logic [1:0] bp,
                       input logic tk, input int exp, input string tag);
    if_pc1 = pc; if_hist1 = 2'b00;
    bu_upd1 = upd; bu_pc1 = pc; bu_hist1 = 2'b00; bu_pred1 = bp; bu_tk1 = tk;
    @(posedge clk); #1;
    bu_upd1 = 1'b0;
    if (!upd) check_val(tag, pred1, exp);
  endtask

  initial begin
    int n;
    logic [31:0] pc;
    logic [1:0]  h;
    logic [1:0]  held;

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 1);
    check_val("rst_pred", pred, 0);
    check_val("rst_busy1", busy1, 1);
    check_val("rst_pred1", pred1, 0);

    // Initial sweep length and content.
    rstn = 1'b1;
    wait_init(1'b0, n);
    check_val("init_cycles", n, DEPTH);
    fill_model(2'b01);
    for (int i = 0; i < 6; i++) begin
      pc = $urandom; h = 2'($urandom);
      step0(1'b0, pc, h, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "init_val");
    end

    // Saturation at both ends.
    step0(1'b0, 32'h0, 2'b00, 1'b1, 32'h200, 2'b10, 1'b1, 2'b11, "sat_wr_hi");
    step0(1'b0, 32'h0, 2'b00, 1'b1, 32'h200, 2'b01, 1'b0, 2'b00, "sat_wr_lo");
    step0(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "sat_hi");
    check_val("sat_hi_abs", pred, 3);
    step0(1'b0, 32'h200, 2'b01, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "sat_lo");
    check_val("sat_lo_abs", pred, 0);

    // Same-cycle write/read bypass, and no bypass on a different history.
    step0(1'b0, 32'h104, 2'b00, 1'b1, 32'h104, 2'b00, 1'b1, 2'b01, "bypass");
    check_val("bypass_abs", pred, 2);
    step0(1'b0, 32'h108, 2'b11, 1'b1, 32'h108, 2'b00, 1'b1, 2'b01, "no_bypass");
    check_val("no_bypass_abs", pred, 1);

    // Stall holds the output even when the held entry is rewritten.
    step0(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "pre_stall");
    held = pred;
    step0(1'b1, 32'h104, 2'b00, 1'b1, 32'h200, 2'b10, 1'b0, 2'b01, "stall0");
    step0(1'b1, 32'h300, 2'b01, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "stall1");
    step0(1'b1, 32'h400, 2'b11, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "stall2");
    check_val("stall_hold_abs", pred, held);
    step0(1'b0, 32'h104, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "unstall");
    check_val("unstall_abs", pred, 2);

    // Randomised traffic with collisions against the model.
    for (int i = 0; i < 400; i++) begin
      step0(($urandom_range(0, 3) == 0), 32'h100 + 4 * $urandom_range(0, 7),
            2'($urandom), $urandom_range(0, 1) == 1, 32'h100 + 4 * $urandom_range(0, 7),
            2'($urandom), 1'($urandom), 2'($urandom), "rand");
    end

    // Clear mid-run with a simultaneous update, then updates during the sweep.
    bp_clear = 1'b1; bu_upd = 1'b1; bu_pc = 32'h0; bu_hist = 2'b00;
    bu_tk = 1'b1; bu_pred = 2'b10; if_stall = 1'b0;
    @(posedge clk); #1;
    bp_clear = 1'b0;
    n = 0;
    while (busy && n < 10000) begin
      bu_upd = 1'b1; bu_pc = 4 * $urandom_range(0, 63); bu_hist = 2'b00;
      bu_tk = 1'b1; bu_pred = 2'b10;
      @(posedge clk); #1;
      n++;
      if (n == 100) check_val("sweep_pred", pred, 0);
    end
    bu_upd = 1'b0;
    check_val("clear_cycles", n, DEPTH);
    fill_model(2'b01);
    step0(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "clr_200");
    step0(1'b0, 32'h104, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "clr_104");
    for (int i = 0; i < 64; i++) begin
      step0(1'b0, 4 * i, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "clr_low");
    end
    for (int i = 0; i < 32; i++) begin
      step0(1'b0, $urandom, 2'($urandom), 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, "clr_rand");
    end

    // Instance 1: reset during the sweep restarts it from entry 0.
    rstn1 = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_val("rvc_busy_mid", busy1, 1);
    rstn1 = 1'b0;
    #1;
    check_val("rvc_rst_busy", busy1, 1);
    check_val("rvc_rst_pred", pred1, 0);
    @(posedge clk); #1;
    rstn1 = 1'b1;
    wait_init(1'b1, n);
    check_val("rvc_init_cycles", n, DEPTH);

    // Halfword-aligned PCs select distinct entries.
    step1(32'h202, 1'b1, 2'b11, 1'b1, 0, "");
    step1(32'h200, 1'b0, 2'b00, 1'b0, 1, "rvc_200");
    step1(32'h202, 1'b0, 2'b00, 1'b0, 3, "rvc_202");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
